// File: rtl/ret_addr_stack.sv
// Return-address stack: pushes return IPs on calls, predicts targets on returns
// with a one-cycle registered output, and exposes a pointer/count checkpoint.
module ret_addr_stack #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_W    = 4,
  parameter int unsigned IP_WIDTH = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_en,
  input  logic [IP_WIDTH-1:0] push_addr,
  input  logic                pop_en,
  input  logic                restore_en,
  input  logic [PTR_W-1:0]    restore_ptr,
  input  logic [PTR_W:0]      restore_cnt,
  output logic [PTR_W-1:0]    ckpt_ptr,
  output logic [PTR_W:0]      ckpt_cnt,
  output logic                ret_valid,
  output logic [IP_WIDTH-1:0] ret_target,
  output logic                underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [IP_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    tp, tpInc, tpDec, tpNext, memWAddr;
  logic [PTR_W:0]      cnt, cntNext;
  logic                isEmpty, memWe, retTargetLoad, retValidNext, underflowNext;

  assign tpInc    = tp + 1'b1;
  assign tpDec    = tp - 1'b1;
  assign isEmpty  = (cnt == '0);
  assign ckpt_ptr = tp;
  assign ckpt_cnt = cnt;

  always_comb begin
    tpNext        = tp;
    cntNext       = cnt;
    memWe         = 1'b0;
    memWAddr      = tpInc;
    retTargetLoad = 1'b0;
    retValidNext  = 1'b0;
    underflowNext = 1'b0;
    if (restore_en) begin
      tpNext  = restore_ptr;
      cntNext = (restore_cnt > FULL_CNT) ? FULL_CNT : restore_cnt;
    end else if (push_en && pop_en) begin
      memWe = 1'b1;
      if (!isEmpty) begin
        // Return-through-call: old top is predicted, then replaced in place.
        retTargetLoad = 1'b1;
        retValidNext  = 1'b1;
        memWAddr      = tp;
      end else begin
        underflowNext = 1'b1;
        tpNext        = tpInc;
        cntNext       = (PTR_W+1)'(1);
      end
    end else if (push_en) begin
      memWe   = 1'b1;
      tpNext  = tpInc;
      cntNext = (cnt == FULL_CNT) ? cnt : cnt + 1'b1;
    end else if (pop_en) begin
      if (!isEmpty) begin
        retTargetLoad = 1'b1;
        retValidNext  = 1'b1;
        tpNext        = tpDec;
        cntNext       = cnt - 1'b1;
      end else begin
        underflowNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp         <= '0;
      cnt        <= '0;
      ret_valid  <= 1'b0;
      ret_target <= '0;
      underflow  <= 1'b0;
    end else begin
      tp        <= tpNext;
      cnt       <= cntNext;
      ret_valid <= retValidNext;
      underflow <= underflowNext;
      if (retTargetLoad) ret_target <= mem[tp];
    end
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= push_addr;
  end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Return-address stack that consumes the call/return hints produced by jump decode: pushCallStack on calls, popCallStack on returns.
- On a call it stores the return IP. On a return it delivers a registered predicted target, one cycle later, to the fetch redirect logic.
- Keeps a pointer/count checkpoint that the backend restores on a mispredict or flush.

Parameters:
DEPTH, 16, number of entries (power of 2)
PTR_W, 4, log2(DEPTH)
IP_WIDTH, 48, return address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
push_en  input  1  call decoded (pushCallStack)
push_addr  input  IP_WIDTH  return IP (call IP + insn length)
pop_en  input  1  return decoded (popCallStack)
restore_en  input  1  mispredict/flush recovery
restore_ptr  input  PTR_W  checkpointed top pointer
restore_cnt  input  PTR_W+1  checkpointed occupancy
ckpt_ptr  output  PTR_W  current top pointer (combinational from state)
ckpt_cnt  output  PTR_W+1  current occupancy (combinational)
ret_valid  output  1  registered: prediction valid this cycle
ret_target  output  IP_WIDTH  registered predicted return target
underflow  output  1  registered one-cycle pulse: pop on empty stack

Behaviour:
- State: mem[DEPTH] (no reset), tp (PTR_W), cnt (0..DEPTH).
- Reset values:
  - tp=0, cnt=0.
  - ret_valid=0, ret_target=0, underflow=0.
  - Asynchronous reset takes effect mid-operation. Any pending prediction is discarded.
- Top entry is mem[tp]. The stack is empty when cnt==0.
- Priority per cycle: restore_en > (push_en & pop_en) > push_en > pop_en.
- restore_en:
  - tp<=restore_ptr; cnt<=min(restore_cnt,DEPTH).
  - push/pop in the same cycle are ignored.
  - ret_valid<=0, underflow<=0.
  - mem is unchanged.
- push only:
  - tp<=tp+1 (wraps DEPTH-1->0); mem[tp+1]<=push_addr.
  - cnt<=cnt+1, saturating at DEPTH.
  - At DEPTH the oldest entry is silently overwritten.
  - ret_valid<=0.
- pop only, cnt!=0:
  - ret_target<=mem[tp]; ret_valid<=1.
  - tp<=tp-1 (wraps 0->DEPTH-1); cnt<=cnt-1.
- pop only, cnt==0:
  - ret_valid<=0; ret_target holds; underflow<=1.
  - tp and cnt are unchanged.
- push & pop same cycle (return-through-call):
  - If cnt!=0: ret_target<=mem[tp], ret_valid<=1, then mem[tp]<=push_addr.
  - If cnt==0: underflow<=1, ret_valid<=0, mem[tp+1]<=push_addr, tp<=tp+1, cnt<=1.
  - In the cnt!=0 case tp and cnt are unchanged. The old top is read before the write.
- Idle cycle: ret_valid<=0, underflow<=0, ret_target holds.
- Latency:
  - Pop to ret_valid is exactly 1 cycle.
  - Back-to-back pops are supported, one per cycle, with no bubble.
- Push then pop in the next cycle returns the pushed address. Write-before-read ordering holds across cycles.
- Checkpoint limitation:
  - Entries overwritten by pushes after a checkpoint are not recovered.
  - Restore rebuilds pointer and count only.
  - Verification must treat post-restore targets of overwritten slots as don't-care for correctness, but pointer/count must match exactly.

Test Plan:
- Reset, then push 0x1000, 0x2000, 0x3000, then 3 pops on consecutive cycles -> ret_target 0x3000, 0x2000, 0x1000 on cycles +1,+2,+3 with ret_valid=1; final cnt=0, tp=0.
- Pop on empty stack after reset -> next cycle ret_valid=0, underflow=1 for one cycle; ckpt_ptr=0, ckpt_cnt=0.
- 17 pushes 0x100..0x1100 (step 0x100), then 17 pops -> first 16 pops return 0x1100 down to 0x200; cnt saturates at 16; 17th pop gives underflow=1.
- push_en=pop_en=1 with top=0xAAAA, push_addr=0xBBBB -> ret_target=0xAAAA next cycle; cnt unchanged; following pop returns 0xBBBB.
- Record ckpt_ptr=2, ckpt_cnt=2; push 0x5000; pop; then restore_en with (2,2) together with pop_en=1 -> pop ignored, ret_valid=0, ckpt_ptr=2, ckpt_cnt=2; next pop returns the entry at slot 2.
- Assert rst mid-sequence, with cnt=5 and a pop issued in the same cycle -> outputs go to 0 immediately (asynchronous); after release, a pop gives underflow=1.
